// File: rtl/regfile_wr_pkg.sv
// Shared types and constants for the register-file write arbiter.
package regfile_wr_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int XZR_INDEX  = 31;

  // Writeback producers; also the encoding of the order flag and round-robin pointer.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_t;

  // One pending register-file write.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bus bundle between the two writeback producers, the arbiter and the register file.
//
// Handshake (alu_* and mem_*): a transfer happens at a posedge where valid && ready
// are both high. ready is driven from registered state only (no path from valid),
// so a producer may look at ready before deciding what to present. A producer should
// hold reg/data stable while valid is high and ready is low.
interface regfile_write_arbiter_if #(
  parameter int DATA_WIDTH = regfile_wr_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_wr_pkg::ADDR_WIDTH,
  parameter int CNT_WIDTH  = 16
);

  logic                  alu_valid;
  logic                  alu_ready;
  logic [ADDR_WIDTH-1:0] alu_reg;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_reg;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_reg;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  stall_cnt;

  // Producer / register-file side.
  modport master (
    output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
    input  alu_ready, mem_ready, wr_en, wr_reg, wr_data, busy, stall_cnt
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
    output alu_ready, mem_ready, wr_en, wr_reg, wr_data, busy, stall_cnt
  );

endinterface

// File: rtl/rf_wr_holding_buf.sv
// One-entry holding buffer for a writeback producer. A load always wins over a
// clear, so a granted buffer can take a new entry in the same cycle.
module rf_wr_holding_buf
  import regfile_wr_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      load,
  input  wr_entry_t load_entry,
  input  logic      clear,
  output logic      valid,
  output wr_entry_t entry
);

  // Occupancy and payload: load has priority over clear-on-grant.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      entry <= '0;
    end else if (load) begin
      valid <= 1'b1;
      entry <= load_entry;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between the ALU and load writeback paths.
// Each path has a one-entry buffer; the older buffer wins, and a round-robin
// pointer breaks ties between entries loaded in the same cycle.
// Optional build macro XZR_DISCARD_EN: requests to register 31 are accepted but dropped.
module regfile_write_arbiter
  import regfile_wr_pkg::*;
#(
  parameter int DATA_WIDTH = regfile_wr_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_wr_pkg::ADDR_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input logic clock,
  input logic reset,
  regfile_write_arbiter_if.slave bus
);

  wr_entry_t             bufa_entry, bufm_entry;
  wr_entry_t             load_entry_a, load_entry_m;
  logic                  bufa_valid, bufm_valid;
  logic                  grant_a, grant_m;
  logic                  acc_a, acc_m;
  logic                  load_a, load_m;
  logic                  next_a_valid, next_m_valid;
  logic                  stall;
  req_t                  order_q;       // which buffer loaded first when loaded apart
  req_t                  rr_ptr_q;      // tie-break when both loaded in the same cycle
  logic                  same_cycle_q;  // both current entries loaded at the same edge
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_reg_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [CNT_WIDTH-1:0]  stall_cnt_q;

  assign load_entry_a = '{reg_addr: bus.alu_reg, data: bus.alu_data};
  assign load_entry_m = '{reg_addr: bus.mem_reg, data: bus.mem_data};

  rf_wr_holding_buf u_bufa (
    .clock      (clock),
    .reset      (reset),
    .load       (load_a),
    .load_entry (load_entry_a),
    .clear      (grant_a),
    .valid      (bufa_valid),
    .entry      (bufa_entry)
  );

  rf_wr_holding_buf u_bufm (
    .clock      (clock),
    .reset      (reset),
    .load       (load_m),
    .load_entry (load_entry_m),
    .clear      (grant_m),
    .valid      (bufm_valid),
    .entry      (bufm_entry)
  );

  // Grant: sole valid buffer wins; with both valid, older wins, ties go to the pointer.
  always_comb begin
    grant_a = 1'b0;
    grant_m = 1'b0;
    if (bufa_valid && bufm_valid) begin
      if (same_cycle_q) begin
        grant_a = (rr_ptr_q == REQ_ALU);
        grant_m = (rr_ptr_q == REQ_MEM);
      end else begin
        grant_a = (order_q == REQ_ALU);
        grant_m = (order_q == REQ_MEM);
      end
    end else begin
      grant_a = bufa_valid;
      grant_m = bufm_valid;
    end
  end

  // Ready comes from registered state (and reset) only.
  assign bus.alu_ready = !reset && (!bufa_valid || grant_a);
  assign bus.mem_ready = !reset && (!bufm_valid || grant_m);

  assign acc_a = bus.alu_valid && bus.alu_ready;
  assign acc_m = bus.mem_valid && bus.mem_ready;

`ifdef XZR_DISCARD_EN
  // Writes to the zero register complete the handshake but never occupy a buffer.
  assign load_a = acc_a && (bus.alu_reg != ADDR_WIDTH'(XZR_INDEX));
  assign load_m = acc_m && (bus.mem_reg != ADDR_WIDTH'(XZR_INDEX));
`else
  assign load_a = acc_a;
  assign load_m = acc_m;
`endif

  assign next_a_valid = load_a || (bufa_valid && !grant_a);
  assign next_m_valid = load_m || (bufm_valid && !grant_m);

  // Age tracking and round-robin pointer update.
  always_ff @(posedge clock) begin
    if (reset) begin
      order_q      <= REQ_ALU;
      rr_ptr_q     <= REQ_ALU;
      same_cycle_q <= 1'b0;
    end else begin
      if (next_a_valid && next_m_valid) begin
        if (load_a && load_m) begin
          same_cycle_q <= 1'b1;
        end else if (load_a) begin
          same_cycle_q <= 1'b0;
          order_q      <= REQ_MEM;
        end else if (load_m) begin
          same_cycle_q <= 1'b0;
          order_q      <= REQ_ALU;
        end
      end
      if (bufa_valid && bufm_valid && same_cycle_q) begin
        rr_ptr_q <= grant_a ? REQ_MEM : REQ_ALU;
      end
    end
  end

  // Registered write port; address and data hold while no write is issued.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= grant_a || grant_m;
      if (grant_a) begin
        wr_reg_q  <= bufa_entry.reg_addr;
        wr_data_q <= bufa_entry.data;
      end else if (grant_m) begin
        wr_reg_q  <= bufm_entry.reg_addr;
        wr_data_q <= bufm_entry.data;
      end
    end
  end

  assign stall = (bus.alu_valid && !bus.alu_ready) || (bus.mem_valid && !bus.mem_ready);

  // Saturating count of cycles where a valid producer was back-pressured.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_reg    = wr_reg_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.busy      = bufa_valid || bufm_valid;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter. The reference model tracks each
// pending entry with the cycle it was loaded and grants by age, so it is built
// from the arbitration rules rather than the RTL's flag encoding.
module tb_regfile_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 16;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  regfile_write_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] obs_q[$];

  // Reference model state.
  logic          ma_v, mm_v;
  logic [AW-1:0] ma_reg, mm_reg;
  logic [DW-1:0] ma_data, mm_data;
  int            ma_t, mm_t;
  int            m_rr;      // 0 = ALU next on a tie, 1 = MEM
  int            m_stall;
  int            cyc;
  logic          last_ra, last_rm;  // model readiness in the last driven cycle
  logic          dut_ra, dut_rm;    // DUT readiness sampled in the same cycle

  // Monitor: record every write issued on the register-file port.
  always @(negedge clock) begin
    if (bus.wr_en === 1'b1) obs_q.push_back({bus.wr_reg, bus.wr_data});
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    ma_v = 1'b0; mm_v = 1'b0;
    ma_reg = '0; mm_reg = '0; ma_data = '0; mm_data = '0;
    ma_t = 0; mm_t = 0; m_rr = 0; m_stall = 0; cyc = 0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clock); #1;
    reset = 1'b1;
    bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Drive one cycle and advance the model by one edge.
  task automatic drive(input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                       input logic mv, input logic [AW-1:0] mr, input logic [DW-1:0] md);
    logic ga, gm, la, lm;
    @(negedge clock); #1;
    bus.alu_valid = av; bus.alu_reg = ar; bus.alu_data = ad;
    bus.mem_valid = mv; bus.mem_reg = mr; bus.mem_data = md;
    if (ma_v && mm_v) begin
      ga = (ma_t == mm_t) ? (m_rr == 0) : (ma_t < mm_t);
      gm = !ga;
    end else begin
      ga = ma_v;
      gm = mm_v;
    end
    last_ra = !ma_v || ga;
    last_rm = !mm_v || gm;
    #1;
    dut_ra = bus.alu_ready;
    dut_rm = bus.mem_ready;
    @(posedge clock);
    if ((av && !last_ra) || (mv && !last_rm)) begin
      if (m_stall < (1 << CW) - 1) m_stall++;
    end
    if (ga) exp_q.push_back({ma_reg, ma_data});
    if (gm) exp_q.push_back({mm_reg, mm_data});
    if (ma_v && mm_v && ma_t == mm_t) m_rr = ga ? 1 : 0;
    if (ga) ma_v = 1'b0;
    if (gm) mm_v = 1'b0;
    la = av && last_ra;
    lm = mv && last_rm;
`ifdef XZR_DISCARD_EN
    if (ar == AW'(31)) la = 1'b0;
    if (mr == AW'(31)) lm = 1'b0;
`endif
    if (la) begin ma_v = 1'b1; ma_reg = ar; ma_data = ad; ma_t = cyc; end
    if (lm) begin mm_v = 1'b1; mm_reg = mr; mm_data = md; mm_t = cyc; end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
    bus.alu_reg = '0; bus.alu_data = '0; bus.mem_reg = '0; bus.mem_data = '0;
    @(posedge clock); @(posedge clock); #1;
    n_checks++;
    if (bus.alu_ready === 1'b0 && bus.mem_ready === 1'b0) n_pass++;
    else $display("FAIL reset_ready_low: got alu=%b mem=%b want 0 0", bus.alu_ready, bus.mem_ready);
    n_checks++;
    if (bus.wr_en === 1'b0 && bus.wr_reg === '0 && bus.wr_data === '0) n_pass++;
    else $display("FAIL reset_wr_port: got en=%b reg=%0d data=%h want 0 0 0", bus.wr_en, bus.wr_reg, bus.wr_data);
    n_checks++;
    if (bus.busy === 1'b0 && bus.stall_cnt === '0) n_pass++;
    else $display("FAIL reset_busy_stall: got busy=%b stall=%0d want 0 0", bus.busy, bus.stall_cnt);
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.alu_ready === 1'b1 && bus.mem_ready === 1'b1) n_pass++;
    else $display("FAIL post_reset_ready: got alu=%b mem=%b want 1 1", bus.alu_ready, bus.mem_ready);
    model_reset();
  endtask

  task automatic test_alu_only();
    do_reset();
    drive(1'b1, AW'(3), 32'h0000_00AA, 1'b0, '0, '0);
    n_checks++;
    if (bus.wr_en === 1'b0 && bus.busy === 1'b1) n_pass++;
    else $display("FAIL alu_only_edge_n: got en=%b busy=%b want 0 1", bus.wr_en, bus.busy);
    idle(1);
    n_checks++;
    if (bus.wr_en === 1'b1 && bus.wr_reg === AW'(3) && bus.wr_data === 32'h0000_00AA && bus.busy === 1'b0) n_pass++;
    else $display("FAIL alu_only_write: got en=%b reg=%0d data=%h busy=%b want 1 3 000000aa 0",
                  bus.wr_en, bus.wr_reg, bus.wr_data, bus.busy);
    idle(1);
    n_checks++;
    if (bus.wr_en === 1'b0 && bus.wr_reg === AW'(3) && bus.wr_data === 32'h0000_00AA) n_pass++;
    else $display("FAIL alu_only_hold: got en=%b reg=%0d data=%h want 0 3 000000aa", bus.wr_en, bus.wr_reg, bus.wr_data);
    idle(3);
    n_checks++;
    if (obs_q.size() == 1) n_pass++;
    else $display("FAIL alu_only_count: got %0d writes want 1", obs_q.size());
  endtask

  task automatic test_simultaneous();
    do_reset();
    drive(1'b1, AW'(4), 32'h11, 1'b1, AW'(5), 32'h22);
    idle(4);
    // Pointer should now favour MEM on the next tie.
    drive(1'b1, AW'(4), 32'h33, 1'b1, AW'(5), 32'h44);
    idle(4);
    n_checks++;
    if (obs_q.size() == 4) n_pass++;
    else $display("FAIL simul_count: got %0d writes want 4", obs_q.size());
    if (obs_q.size() == 4) begin
      n_checks++;
      if (obs_q[0] === {AW'(4), 32'h11} && obs_q[1] === {AW'(5), 32'h22}) n_pass++;
      else $display("FAIL simul_first_round: got %h %h want alu then mem", obs_q[0], obs_q[1]);
      n_checks++;
      if (obs_q[2] === {AW'(5), 32'h44} && obs_q[3] === {AW'(4), 32'h33}) n_pass++;
      else $display("FAIL simul_pointer_mem: got %h %h want mem then alu", obs_q[2], obs_q[3]);
    end
  endtask

  task automatic test_order();
    do_reset();
    // MEM reg 7 loads alongside an ALU entry, loses the tie, and is still waiting
    // when the ALU writes reg 7 again: the older MEM write must go first.
    drive(1'b1, AW'(1), 32'hA, 1'b1, AW'(7), 32'h1);
    drive(1'b1, AW'(7), 32'h2, 1'b0, '0, '0);
    idle(4);
    n_checks++;
    if (obs_q.size() == 3 && obs_q[0] === {AW'(1), 32'hA} && obs_q[1] === {AW'(7), 32'h1}
        && obs_q[2] === {AW'(7), 32'h2}) n_pass++;
    else $display("FAIL order_same_reg: got %0d writes, second=%h third=%h want 7:1 then 7:2",
                  obs_q.size(), (obs_q.size() > 1) ? obs_q[1] : '0, (obs_q.size() > 2) ? obs_q[2] : '0);
  endtask

  task automatic test_back_to_back();
    int ready_low;
    int en_low;
    do_reset();
    ready_low = 0;
    en_low = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, AW'(i + 8), DW'(32'hC0 + i), 1'b0, '0, '0);
      if (dut_ra !== 1'b1) ready_low++;
      if (i > 0 && bus.wr_en !== 1'b1) en_low++;
    end
    idle(1);
    if (bus.wr_en !== 1'b1) en_low++;
    n_checks++;
    if (ready_low == 0) n_pass++;
    else $display("FAIL b2b_ready: got %0d cycles with alu_ready low want 0", ready_low);
    n_checks++;
    if (en_low == 0) n_pass++;
    else $display("FAIL b2b_consecutive: got %0d gaps in wr_en want 0", en_low);
    idle(3);
    n_checks++;
    if (obs_q.size() == 8 && bus.stall_cnt === '0) n_pass++;
    else $display("FAIL b2b_count_stall: got %0d writes stall=%0d want 8 0", obs_q.size(), bus.stall_cnt);
    n_checks++;
    if (obs_q.size() == 8 && obs_q[7] === {AW'(15), 32'hC7}) n_pass++;
    else $display("FAIL b2b_last: got %h want 0f/000000c7", (obs_q.size() == 8) ? obs_q[7] : '0);
  endtask

  task automatic test_contention();
    int ai, mi, alt_bad;
    do_reset();
    ai = 0; mi = 0; alt_bad = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, AW'(ai), DW'(32'hA0 + ai), 1'b1, AW'(16 + mi), DW'(32'hB0 + mi));
      if (last_ra) ai++;
      if (last_rm) mi++;
    end
    idle(5);
    n_checks++;
    if (obs_q.size() == 11 && exp_q.size() == 11) n_pass++;
    else $display("FAIL contention_count: got %0d writes (model %0d) want 11", obs_q.size(), exp_q.size());
    foreach (obs_q[k]) begin
      if (obs_q[k][7:4] !== ((k % 2 == 0) ? 4'hA : 4'hB)) alt_bad++;
    end
    n_checks++;
    if (alt_bad == 0) n_pass++;
    else $display("FAIL contention_alternate: got %0d out-of-turn writes want 0", alt_bad);
    n_checks++;
    if (bus.stall_cnt === CW'(9) && m_stall == 9) n_pass++;
    else $display("FAIL contention_stall: got %0d (model %0d) want 9", bus.stall_cnt, m_stall);
    for (int k = 0; k < exp_q.size(); k++) begin
      n_checks++;
      if (k < obs_q.size() && obs_q[k] === exp_q[k]) n_pass++;
      else $display("FAIL contention_write_%0d: got %h want %h", k, (k < obs_q.size()) ? obs_q[k] : '0, exp_q[k]);
    end
  endtask

  task automatic test_random();
    logic          a_pend, m_pend;
    logic [AW-1:0] a_r, m_r;
    logic [DW-1:0] a_d, m_d;
    int            rdy_bad;
    do_reset();
    a_pend = 1'b0; m_pend = 1'b0; a_r = '0; m_r = '0; a_d = '0; m_d = '0; rdy_bad = 0;
    for (int c = 0; c < 400; c++) begin
      if (!a_pend && $urandom_range(0, 3) != 0) begin
        a_pend = 1'b1; a_r = AW'($urandom_range(0, 31)); a_d = $urandom;
      end
      if (!m_pend && $urandom_range(0, 2) != 0) begin
        m_pend = 1'b1; m_r = AW'($urandom_range(0, 31)); m_d = $urandom;
      end
      drive(a_pend, a_r, a_d, m_pend, m_r, m_d);
      if (dut_ra !== last_ra || dut_rm !== last_rm) rdy_bad++;
      if (a_pend && last_ra) a_pend = 1'b0;
      if (m_pend && last_rm) m_pend = 1'b0;
    end
    idle(5);
    n_checks++;
    if (rdy_bad == 0) n_pass++;
    else $display("FAIL random_ready: got %0d cycles where ready differed from model want 0", rdy_bad);
    n_checks++;
    if (obs_q.size() == exp_q.size()) n_pass++;
    else $display("FAIL random_count: got %0d writes want %0d", obs_q.size(), exp_q.size());
    n_checks++;
    if (bus.stall_cnt === CW'(m_stall)) n_pass++;
    else $display("FAIL random_stall: got %0d want %0d", bus.stall_cnt, m_stall);
    for (int k = 0; k < exp_q.size(); k++) begin
      n_checks++;
      if (k < obs_q.size() && obs_q[k] === exp_q[k]) n_pass++;
      else $display("FAIL random_write_%0d: got %h want %h", k, (k < obs_q.size()) ? obs_q[k] : '0, exp_q[k]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, AW'(2 + i), DW'(32'h50 + i), 1'b1, AW'(12 + i), DW'(32'h60 + i));
    n_checks++;
    if (bus.busy === 1'b1 && bus.stall_cnt !== '0) n_pass++;
    else $display("FAIL mid_before_reset: got busy=%b stall=%0d want 1 nonzero", bus.busy, bus.stall_cnt);
    do_reset();
    n_checks++;
    if (bus.wr_en === 1'b0 && bus.busy === 1'b0 && bus.stall_cnt === '0) n_pass++;
    else $display("FAIL mid_after_reset: got en=%b busy=%b stall=%0d want 0 0 0", bus.wr_en, bus.busy, bus.stall_cnt);
    idle(5);
    n_checks++;
    if (obs_q.size() == 0 && bus.busy === 1'b0) n_pass++;
    else $display("FAIL mid_no_write: got %0d writes busy=%b want 0 0", obs_q.size(), bus.busy);
  endtask

  task automatic test_xzr();
    int want;
    do_reset();
    drive(1'b1, AW'(31), 32'h31, 1'b1, AW'(2), 32'h22);
    idle(4);
`ifdef XZR_DISCARD_EN
    want = 1;
`else
    want = 2;
`endif
    n_checks++;
    if (obs_q.size() == want && exp_q.size() == want) n_pass++;
    else $display("FAIL xzr_count: got %0d writes want %0d", obs_q.size(), want);
    n_checks++;
    if (obs_q.size() > 0 && obs_q[obs_q.size() - 1] === {AW'(2), 32'h22}) n_pass++;
    else $display("FAIL xzr_mem_write: got %h want 02/00000022", (obs_q.size() > 0) ? obs_q[obs_q.size() - 1] : '0);
  endtask

  initial begin
    model_reset();
    last_ra = 1'b0; last_rm = 1'b0; dut_ra = 1'b0; dut_rm = 1'b0;
    test_reset();
    test_alu_only();
    test_simultaneous();
    test_order();
    test_back_to_back();
    test_contention();
    test_random();
    test_reset_mid();
    test_xzr();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (regWrite / writeRegister / writeData) between two writeback producers: ALU result path and memory-load path.
- Each producer gets a one-entry holding buffer behind a valid/ready handshake. A fair arbiter drains the buffers onto a registered write port.
- Sits between the execute/memory stages and the operand-prep register file; its outputs drive the register file's write inputs directly.

Parameters:
- DATA_WIDTH, 32, width of write data.
- ADDR_WIDTH, 5, register address width (32 registers).
- CNT_WIDTH, 16, width of the saturating stall counter.

Ports:
- clock  in  1  main clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU buffer can accept this cycle.
- alu_reg  in  ADDR_WIDTH  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- mem_valid  in  1  load writeback request.
- mem_ready  out  1  load buffer can accept this cycle.
- mem_reg  in  ADDR_WIDTH  load destination register.
- mem_data  in  DATA_WIDTH  load data.
- wr_en  out  1  register file write enable (drives regWrite).
- wr_reg  out  ADDR_WIDTH  register file write address.
- wr_data  out  DATA_WIDTH  register file write data.
- busy  out  1  either holding buffer occupied.
- stall_cnt  out  CNT_WIDTH  cycles in which any valid requester saw ready low.

Behaviour:
- Reset (synchronous, active-high):
  - Both buffers are emptied; any entries held at reset are discarded, with no write issued.
  - wr_en=0, wr_reg=0, wr_data=0, busy=0, stall_cnt=0.
  - Round-robin pointer and order flag reset to ALU.
  - During the reset cycle itself, ready outputs are 0.
- Accept: a transfer occurs when x_valid && x_ready at a posedge; reg and data are captured into buffer x.
- Ready: x_ready = !bufx_valid || grant_x. It depends on registered state only, so there is no combinational path from inputs to ready. A full buffer that is granted accepts a new entry in the same cycle, giving full throughput.
- Arbitration, per cycle, over the buffers that are valid:
  - One valid buffer: it is granted.
  - Both valid, loaded in different cycles: the older one is granted. The order flag records which buffer loaded first, which preserves program order for same-register writes.
  - Both valid, loaded in the same cycle: the round-robin pointer decides. After such a grant the pointer moves to the other requester.
  - No grant: wr_en=0 next cycle.
- Output latency: an entry accepted at edge N is eligible in cycle N+1. If granted, wr_en/wr_reg/wr_data are valid after edge N+1, and the register file commits at edge N+2.
- wr_reg and wr_data hold their last values while wr_en=0.
- A buffer is cleared at the edge where it is granted, unless it reloads in that same cycle.
- The losing buffer waits; at most one cycle of contention delay per entry, so there is no starvation.
- stall_cnt increments when (alu_valid && !alu_ready) || (mem_valid && !mem_ready). It saturates at all-ones and never wraps.
- busy = bufa_valid || bufm_valid, registered state only.
- wr_en is never asserted twice for one accepted entry.

Optional Feature:
- Macro XZR_DISCARD_EN.
- Defined: a request to register 31 (XZR) is accepted (handshake completes normally) but the buffer is not loaded. No wr_en is produced for it, and it does not affect the order flag or pointer.
- Undefined: register 31 is treated like any other register and written normally.

Decomposition:
- Package regfile_wr_pkg:
  - Constants: DATA_WIDTH, ADDR_WIDTH, XZR_INDEX=31.
  - Requester enum: REQ_ALU=0, REQ_MEM=1.
  - Typedef wr_entry_t {reg, data}.
- Sub-module rf_wr_holding_buf: one-entry buffer with valid, load, and clear-on-grant. Instantiated twice; arbiter, order flag, pointer and counter live in the top.

Test Plan:
- ALU only: alu_valid=1, alu_reg=3, alu_data=0x0000_00AA for 1 cycle -> exactly one wr_en pulse two edges later with wr_reg=3, wr_data=0xAA.
- Simultaneous first arrival: alu (reg 4, 0x11) and mem (reg 5, 0x22) in the same cycle after reset -> ALU written first, then mem in the next cycle; pointer now at MEM.
- Order preservation: mem (reg 7, 0x1) in cycle 0, then alu (reg 7, 0x2) arrives while the mem entry is still waiting -> writes appear as 0x1 then 0x2.
- Back-to-back streaming: alu_valid held high for 8 cycles, mem idle -> alu_ready stays 1, eight consecutive wr_en pulses, stall_cnt=0.
- Contention stall: both valid continuously for 10 cycles -> writes alternate ALU/MEM, stall_cnt increments each cycle a ready is low, no entry lost.
- Reset mid-operation: both buffers full, reset asserted one cycle -> no wr_en afterwards, busy=0, stall_cnt=0. With XZR_DISCARD_EN defined, a reg-31 request yields no wr_en.
